// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph patterns (g..a), blank pattern
// and the decoded-digit types used by both the encoder and reader sides.
package seg7_pkg;

  typedef logic [3:0] seg7_hex_t;

  typedef struct packed {
    logic      legal;
    seg7_hex_t value;
  } seg7_dec_t;

  localparam logic [6:0] SEG7_GLYPH_0 = 7'b1000000;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'b1111001;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'b0100100;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'b0110000;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'b0011001;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'b0010010;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'b0000010;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'b1111000;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'b0010000;
  localparam logic [6:0] SEG7_GLYPH_A = 7'b0001000;
  localparam logic [6:0] SEG7_GLYPH_B = 7'b0000011;
  localparam logic [6:0] SEG7_GLYPH_C = 7'b1000110;
  localparam logic [6:0] SEG7_GLYPH_D = 7'b0100001;
  localparam logic [6:0] SEG7_GLYPH_E = 7'b0000110;
  localparam logic [6:0] SEG7_GLYPH_F = 7'b0001110;

  localparam logic [6:0] SEG7_BLANK   = 7'b1111111;

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational glyph decoder: active-low segment pattern to hex nibble, with a
// legal flag that is low for any pattern outside the sixteen hex glyphs.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output seg7_dec_t  dec
);

  always_comb begin
    dec.legal = 1'b1;
    dec.value = 4'h0;
    case (seg_n)
      SEG7_GLYPH_0: dec.value = 4'h0;
      SEG7_GLYPH_1: dec.value = 4'h1;
      SEG7_GLYPH_2: dec.value = 4'h2;
      SEG7_GLYPH_3: dec.value = 4'h3;
      SEG7_GLYPH_4: dec.value = 4'h4;
      SEG7_GLYPH_5: dec.value = 4'h5;
      SEG7_GLYPH_6: dec.value = 4'h6;
      SEG7_GLYPH_7: dec.value = 4'h7;
      SEG7_GLYPH_8: dec.value = 4'h8;
      SEG7_GLYPH_9: dec.value = 4'h9;
      SEG7_GLYPH_A: dec.value = 4'hA;
      SEG7_GLYPH_B: dec.value = 4'hB;
      SEG7_GLYPH_C: dec.value = 4'hC;
      SEG7_GLYPH_D: dec.value = 4'hD;
      SEG7_GLYPH_E: dec.value = 4'hE;
      SEG7_GLYPH_F: dec.value = 4'hF;
      default:      dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Multiplexed seven-segment bus reader: qualifies each digit pattern over STABLE_CYCLES
// identical samples and decodes it. Optional decimal point capture via SEG7_READER_DP_EN.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
`ifdef SEG7_READER_DP_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err,
  output logic [2:0]              err_digit
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic [7:0]            cnt;
  logic [7:0]            cnt_next;
  logic [NUM_DIGITS-1:0] mask;
  logic [NUM_DIGITS-1:0] sel;
  logic [2:0]            idx;
  logic                  legal_sel;
  logic                  same;
  logic                  capture;
  seg7_dec_t             dec;

`ifdef SEG7_READER_DP_EN
  logic r_dp;
`endif

  seg7_glyph_decoder u_dec (
    .seg_n (seg_n),
    .dec   (dec)
  );

  assign sel       = ~an_n;
  assign legal_sel = $onehot(sel);

`ifdef SEG7_READER_DP_EN
  assign same = (an_n == r_an) && (seg_n == r_seg) && (dp_n == r_dp);
`else
  assign same = (an_n == r_an) && (seg_n == r_seg);
`endif

  // Run length saturates at STABLE_CYCLES so a held pattern captures only once
  always_comb begin
    cnt_next = 8'd0;
    if (legal_sel && same)
      cnt_next = (cnt >= STABLE_C) ? STABLE_C : cnt + 8'd1;
    else if (legal_sel)
      cnt_next = 8'd1;
  end

  assign capture = legal_sel && same && (cnt == STABLE_C - 8'd1);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel[i]) idx = 3'(i);
  end

  // Sample register and run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= SEG7_BLANK;
      cnt   <= 8'd0;
`ifdef SEG7_READER_DP_EN
      r_dp  <= 1'b1;
`endif
    end else begin
      r_an  <= an_n;
      r_seg <= seg_n;
      cnt   <= cnt_next;
`ifdef SEG7_READER_DP_EN
      r_dp  <= dp_n;
`endif
    end
  end

  // Capture stage: digit registers, frame mask and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      mask        <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      err_digit   <= 3'd0;
`ifdef SEG7_READER_DP_EN
      digit_dp    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (capture) begin
        if (dec.legal) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
              digits[4*i +: 4] <= dec.value;
              digit_valid[i]   <= 1'b1;
`ifdef SEG7_READER_DP_EN
              digit_dp[i]      <= ~dp_n;
`endif
            end
          end
          if ((mask | sel) == '1) begin
            frame_done <= 1'b1;
            mask       <= '0;
          end else begin
            mask <= mask | sel;
          end
        end else begin
          err         <= 1'b1;
          err_digit   <= idx;
          digit_valid <= digit_valid & an_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scenarios plus randomized scanning checked
// against a history-based reference model. Build with SEG7_READER_DP_EN for the dp case.
module tb_seg7_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ND-1:0]   an_n;
  logic [6:0]      seg_n;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic            frame_done;
  logic            err;
  logic [2:0]      err_digit;
`ifdef SEG7_READER_DP_EN
  logic            dp_n;
  logic [ND-1:0]   digit_dp;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
`ifdef SEG7_READER_DP_EN
    .dp_n        (dp_n),
    .digit_dp    (digit_dp),
`endif
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err         (err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [ND-1:0] a, input logic [6:0] s);
    an_n  = a;
    seg_n = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = 7'h7F;
`ifdef SEG7_READER_DP_EN
    dp_n  = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({digits, digit_valid, frame_done, err, err_digit} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %h/%b/%b/%b/%0d want all zero",
               digits, digit_valid, frame_done, err, err_digit);
    end
  endtask

  task automatic test_single();
    do_reset();
    repeat (3) drive(4'b1110, 7'b0110000);
    vectors++;
    if (digit_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_early_valid got %b want 0000", digit_valid);
    end
    drive(4'b1110, 7'b0110000);
    vectors++;
    if ({digits[3:0], digit_valid, err, frame_done} !== {4'h3, 4'b0001, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_capture got dig=%h val=%b err=%b fd=%b want 3/0001/0/0",
               digits[3:0], digit_valid, err, frame_done);
    end
  endtask

  task automatic test_scan();
    logic [6:0] g [4];
    logic [ND-1:0] a;
    int fd_count;
    g[0] = 7'b1111001; g[1] = 7'b0001000; g[2] = 7'b0000011; g[3] = 7'b0001110;
    fd_count = 0;
    do_reset();
    for (int d = 0; d < 4; d++) begin
      a = 4'b0001 << d;
      a = ~a;
      for (int c = 0; c < 6; c++) begin
        drive(a, g[d]);
        if (frame_done) fd_count++;
        if (d == 3 && c == 3) begin
          vectors++;
          if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL scan_fd_edge got %b want 1", frame_done);
          end
        end
      end
    end
    vectors++;
    if ({digits, digit_valid} !== {16'hFBA1, 4'b1111}) begin
      miscompares++;
      $display("FAIL scan_digits got %h/%b want fba1/1111", digits, digit_valid);
    end
    vectors++;
    if (fd_count !== 1) begin
      miscompares++;
      $display("FAIL scan_fd_count got %0d want 1", fd_count);
    end
  endtask

  task automatic test_illegal();
    int err_count;
    err_count = 0;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1101, 7'b1111111);
      if (err) err_count++;
      if (c == 3) begin
        vectors++;
        if ({err, err_digit} !== {1'b1, 3'd1}) begin
          miscompares++;
          $display("FAIL illegal_pulse got err=%b idx=%0d want 1/1", err, err_digit);
        end
      end
    end
    vectors++;
    if ({err_count[3:0], digit_valid, digits} !== {4'd1, 4'b1101, 16'hFBA1}) begin
      miscompares++;
      $display("FAIL illegal_after got cnt=%0d val=%b dig=%h want 1/1101/fba1",
               err_count, digit_valid, digits);
    end
  endtask

  task automatic test_reset_midrun();
    repeat (3) drive(4'b1011, gl[7]);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({digits, digit_valid, frame_done, err, err_digit} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset got %h/%b/%b/%b/%0d want all zero",
               digits, digit_valid, frame_done, err, err_digit);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive(4'b1011, gl[7]);
    vectors++;
    if (digit_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrun_early got %b want 0000", digit_valid);
    end
    drive(4'b1011, gl[7]);
    vectors++;
    if ({digits, digit_valid} !== {16'h0700, 4'b0100}) begin
      miscompares++;
      $display("FAIL midrun_capture got %h/%b want 0700/0100", digits, digit_valid);
    end
  endtask

  task automatic test_glitch();
    int events;
    events = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(4'b1110, (c == 3) ? gl[6] : gl[5]);
      if (frame_done || err || digit_valid != 0) events++;
    end
    vectors++;
    if (events !== 0) begin
      miscompares++;
      $display("FAIL glitch_capture got %0d events want 0", events);
    end
    for (int c = 0; c < 10; c++) begin
      drive(4'b1100, gl[2]);
      if (frame_done || err || digit_valid != 0) events++;
    end
    vectors++;
    if (events !== 0) begin
      miscompares++;
      $display("FAIL blank_multi got %0d events want 0", events);
    end
  endtask

`ifdef SEG7_READER_DP_EN
  task automatic test_dp();
    do_reset();
    dp_n = 1'b0;
    repeat (4) drive(4'b1011, gl[8]);
    dp_n = 1'b1;
    vectors++;
    if ({digits[11:8], digit_dp} !== {4'h8, 4'b0100}) begin
      miscompares++;
      $display("FAIL dp_capture got %h/%b want 8/0100", digits[11:8], digit_dp);
    end
  endtask
`endif

  // Reference model: a capture happens when the newest SC samples since reset are
  // identical and single-select, and the sample before them (if any) differs.
  task automatic test_random();
    logic [ND+6:0] hist[$];
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_val, m_mask;
    logic          m_fd, m_err;
    logic [2:0]    m_errd;
    logic [4*ND-1:0] m_digits;
    logic [ND-1:0] a;
    logic [6:0]    s;
    logic [ND+6:0] smp;
    int hold, zeros, pos, cycles;
    bit run_ok, found;
    logic [3:0] v;
    do_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_val = '0; m_mask = '0; m_fd = 0; m_err = 0; m_errd = 3'd0;
    cycles = 0;
    while (cycles < 3000) begin
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 9) < 8) begin
        a = '1;
        a[$urandom_range(0, ND-1)] = 1'b0;
      end else a = ND'($urandom);
      s = ($urandom_range(0, 15) < 13) ? gl[$urandom_range(0, 15)] : 7'($urandom);
      for (int h = 0; h < hold; h++) begin
        drive(a, s);
        cycles++;
        smp = {a, s};
        hist.push_back(smp);
        if (hist.size() > SC + 1) void'(hist.pop_front());
        zeros = 0; pos = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) begin zeros++; pos = i; end
        run_ok = (zeros == 1) && (hist.size() >= SC);
        for (int k = 0; k < SC; k++)
          if (run_ok && hist[hist.size()-1-k] != smp) run_ok = 0;
        if (run_ok && hist.size() == SC + 1 && hist[0] == smp) run_ok = 0;
        m_fd = 0; m_err = 0;
        if (run_ok) begin
          found = 0; v = 4'h0;
          for (int g = 0; g < 16; g++) if (gl[g] == s) begin found = 1; v = 4'(g); end
          if (found) begin
            m_dig[pos] = v;
            m_val[pos] = 1'b1;
            m_mask[pos] = 1'b1;
            if (m_mask == '1) begin m_fd = 1; m_mask = '0; end
          end else begin
            m_err = 1; m_errd = 3'(pos); m_val[pos] = 1'b0;
          end
        end
        for (int i = 0; i < ND; i++) m_digits[4*i +: 4] = m_dig[i];
        vectors++;
        if ({digits, digit_valid, frame_done, err, err_digit} !==
            {m_digits, m_val, m_fd, m_err, m_errd}) begin
          miscompares++;
          $display("FAIL random_cycle%0d got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", cycles,
                   digits, digit_valid, frame_done, err, err_digit,
                   m_digits, m_val, m_fd, m_err, m_errd);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = 7'h7F;
`ifdef SEG7_READER_DP_EN
    dp_n  = 1'b1;
`endif
    test_reset();
    test_single();
    test_scan();
    test_illegal();
    test_reset_midrun();
    test_glitch();
`ifdef SEG7_READER_DP_EN
    test_dp();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
